vga_timing_gen: RTL

Generates 640x480 @ 60 Hz VGA raster timing: horizontal/vertical counters, active-low sync pulses, the active-video qualifier `blank`, and the `DrawX`/`DrawY` coordinates consumed by every sprite/palette drawing block. It is the producer end of the `DrawX`/`DrawY`/`blank` interface: drawing logic samples these and returns RGB one `vga_clk` later. All outputs are registered and mutually aligned, so consumers never see a coordinate paired with the wrong sync or blank value.

---
 rtl/vga_timing_gen.sv | 88 ++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, active-low syncs, visible-region
// qualifier and line/frame pulses, all registered together so they stay mutually aligned.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       clk_en,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic       line_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int HS_LO = H_VISIBLE + H_FRONT;
  localparam int HS_HI = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int VS_LO = V_VISIBLE + V_FRONT;
  localparam int VS_HI = V_VISIBLE + V_FRONT + V_SYNC;

  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

  // 10-bit counters cannot represent a larger raster.
  if ((H_TOTAL - 1) >= 1024 || (V_TOTAL - 1) >= 1024) begin : g_bad_raster
    $error("vga_timing_gen: raster totals exceed 10-bit counter range");
  end

  function automatic logic in_window(input logic [9:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

  function automatic logic is_visible(input logic [9:0] h, input logic [9:0] v);
    return (int'(h) < H_VISIBLE) && (int'(v) < V_VISIBLE);
  endfunction

  logic [9:0] hn;
  logic [9:0] vn;
  logic       h_wrap;

  // Stage p0: next raster position
  always_comb begin
    h_wrap = (DrawX == H_MAX);
    hn     = h_wrap ? 10'd0 : DrawX + 10'd1;
    vn     = DrawY;
    if (h_wrap) begin
      vn = (DrawY == V_MAX) ? 10'd0 : DrawY + 10'd1;
    end
  end

  // Stage p1: counters and decode registered on the same edge
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (clk_en) begin
        DrawX       <= hn;
        DrawY       <= vn;
        hs          <= ~in_window(hn, HS_LO, HS_HI);
        vs          <= ~in_window(vn, VS_LO, VS_HI);
        blank       <= is_visible(hn, vn);
        line_start  <= (hn == 10'd0);
        frame_start <= (hn == 10'd0) && (vn == 10'd0);
      end
    end
  end

endmodule
